// File: rtl/regfile_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bist_ctrl
// Description : Register-file BIST sequencer. Writes a pattern over
//               FIRST_REG..LAST_REG, reads it back in pairs and reports the
//               result. Define REGFILE_BIST_INVERT_PASS_EN to add a second
//               pass that uses the inverted pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bist_ctrl #(
    parameter int unsigned FIRST_REG = 8,
    parameter int unsigned LAST_REG  = 25,
    parameter int unsigned DATA_BASE = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic [4:0]  ReadRegister1,
    output logic [4:0]  ReadRegister2,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [5:0]  FailCount,
    output logic [4:0]  FirstFailReg
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_RADDR  = 3'd2;
    localparam logic [2:0] S_RCHECK = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [4:0]  C_FIRST   = 5'(FIRST_REG);
    localparam logic [4:0]  C_LAST    = 5'(LAST_REG);
    localparam logic [31:0] C_FIRST32 = 32'(FIRST_REG);
    localparam logic [31:0] C_BASE    = 32'(DATA_BASE);

    logic [2:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        inv_q, inv_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rreg1_q, rreg1_d;
    logic [4:0]  rreg2_q, rreg2_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [5:0]  failcnt_q, failcnt_d;
    logic [4:0]  firstfail_q, firstfail_d;

    logic        w_last_pair;
    logic        w_mis1;
    logic        w_mis2;
    logic [6:0]  w_fail_sum;

    function automatic logic [31:0] pattern(input logic [4:0] idx, input logic inv);
        logic [31:0] v;
        v = {27'd0, idx} - C_FIRST32 + C_BASE;
        return inv ? ~v : v;
    endfunction

    // Register 0 is hardwired to zero in the target file, whatever was written.
    function automatic logic [31:0] expected(input logic [4:0] idx, input logic inv);
        return (idx == 5'd0) ? 32'd0 : pattern(idx, inv);
    endfunction

    assign w_last_pair = (idx_q == C_LAST) || (({1'b0, idx_q} + 6'd1) == {1'b0, C_LAST});

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 5'd0;
            inv_q       <= 1'b0;
            regwrite_q  <= 1'b0;
            wreg_q      <= 5'd0;
            wdata_q     <= 32'd0;
            rreg1_q     <= 5'd0;
            rreg2_q     <= 5'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            failcnt_q   <= 6'd0;
            firstfail_q <= 5'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            inv_q       <= inv_d;
            regwrite_q  <= regwrite_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
            rreg1_q     <= rreg1_d;
            rreg2_q     <= rreg2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            failcnt_q   <= failcnt_d;
            firstfail_q <= firstfail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        inv_d   = inv_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_WRITE;
                    idx_d   = C_FIRST;
                    inv_d   = 1'b0;
                end
            end
            S_WRITE: begin
                if (idx_q == C_LAST) begin
                    state_d = S_RADDR;
                    idx_d   = C_FIRST;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_RADDR: state_d = S_RCHECK;
            S_RCHECK: begin
                if (w_last_pair) begin
`ifdef REGFILE_BIST_INVERT_PASS_EN
                    if (!inv_q) begin
                        state_d = S_WRITE;
                        idx_d   = C_FIRST;
                        inv_d   = 1'b1;
                    end else begin
                        state_d = S_FINISH;
                    end
`else
                    state_d = S_FINISH;
`endif
                end else begin
                    state_d = S_RADDR;
                    idx_d   = idx_q + 5'd2;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered: their next values follow the next state.
    always_comb begin
        w_mis1      = (state_q == S_RCHECK) && (ReadData1 != expected(rreg1_q, inv_q));
        w_mis2      = (state_q == S_RCHECK) && (rreg2_q != rreg1_q)
                      && (ReadData2 != expected(rreg2_q, inv_q));
        w_fail_sum  = {1'b0, failcnt_q} + {6'd0, w_mis1} + {6'd0, w_mis2};
        regwrite_d  = (state_d == S_WRITE);
        busy_d      = (state_d == S_WRITE) || (state_d == S_RADDR) || (state_d == S_RCHECK);
        done_d      = (state_d == S_FINISH);
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        rreg1_d     = rreg1_q;
        rreg2_d     = rreg2_q;
        pass_d      = pass_q;
        failcnt_d   = failcnt_q;
        firstfail_d = firstfail_q;

        if (state_d == S_WRITE) begin
            wreg_d  = idx_d;
            wdata_d = pattern(idx_d, inv_d);
        end
        if (state_d == S_RADDR) begin
            rreg1_d = idx_d;
            rreg2_d = (idx_d == C_LAST) ? idx_d : idx_d + 5'd1;
        end

        if ((state_q == S_IDLE) && Start) begin
            failcnt_d   = 6'd0;
            firstfail_d = 5'd0;
        end else if (state_q == S_RCHECK) begin
            failcnt_d = (w_fail_sum > 7'd63) ? 6'd63 : w_fail_sum[5:0];
            if ((failcnt_q == 6'd0) && (w_mis1 || w_mis2)) begin
                firstfail_d = w_mis1 ? rreg1_q : rreg2_q;
            end
        end

        if (state_d == S_FINISH) begin
            pass_d = (failcnt_d == 6'd0);
        end
    end

    assign RegWrite      = regwrite_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;
    assign ReadRegister1 = rreg1_q;
    assign ReadRegister2 = rreg2_q;
    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Pass          = pass_q;
    assign FailCount     = failcnt_q;
    assign FirstFailReg  = firstfail_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_bist_ctrl
// Description : Scoreboard bench for regfile_bist_ctrl with a faultable
//               register-file model; two instances cover two configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_bist_ctrl;

`ifdef REGFILE_BIST_INVERT_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam logic [31:0] CORRUPT_XOR = 32'hA5A5_5A5A;

    typedef struct {int inst; logic [4:0] a; logic [31:0] d;} wr_t;
    typedef struct {int inst; logic [4:0] a1; logic [4:0] a2;} rd_t;
    typedef struct {int inst; int cyc; logic pass; logic [5:0] fc; logic [4:0] ff;} res_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        start;
    logic [1:0][31:0]  rd1, rd2, wdata;
    logic [1:0]        rw, busy, done, pass;
    logic [1:0][4:0]   wreg, rr1, rr2, ffr;
    logic [1:0][5:0]   fcnt;
    logic [1:0][31:0]  stuck0, corrupt;
    logic [31:0]       rf0 [32];
    logic [31:0]       rf1 [32];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    wr_t  wr_q[$];
    rd_t  rd_q[$];
    res_t res_q[$];
    res_t last_exp;

    regfile_bist_ctrl #(.FIRST_REG(8), .LAST_REG(25), .DATA_BASE(1)) u_dut0 (
        .Clk(clk), .Reset(rst), .Start(start[0]),
        .ReadData1(rd1[0]), .ReadData2(rd2[0]),
        .RegWrite(rw[0]), .WriteRegister(wreg[0]), .WriteData(wdata[0]),
        .ReadRegister1(rr1[0]), .ReadRegister2(rr2[0]),
        .Busy(busy[0]), .Done(done[0]), .Pass(pass[0]),
        .FailCount(fcnt[0]), .FirstFailReg(ffr[0])
    );

    regfile_bist_ctrl #(.FIRST_REG(0), .LAST_REG(4), .DATA_BASE(7)) u_dut1 (
        .Clk(clk), .Reset(rst), .Start(start[1]),
        .ReadData1(rd1[1]), .ReadData2(rd2[1]),
        .RegWrite(rw[1]), .WriteRegister(wreg[1]), .WriteData(wdata[1]),
        .ReadRegister1(rr1[1]), .ReadRegister2(rr2[1]),
        .Busy(busy[1]), .Done(done[1]), .Pass(pass[1]),
        .FailCount(fcnt[1]), .FirstFailReg(ffr[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int fr(input int k); return (k == 0) ? 8 : 0; endfunction
    function automatic int lr(input int k); return (k == 0) ? 25 : 4; endfunction
    function automatic int db(input int k); return (k == 0) ? 1 : 7; endfunction

    function automatic logic [31:0] pat(input int k, input int i, input int ps);
        logic [31:0] v;
        v = 32'(i - fr(k) + db(k));
        return (ps != 0) ? ~v : v;
    endfunction

    function automatic logic [31:0] fault_val(input logic [4:0] a, input logic [31:0] v,
                                               input logic [31:0] sm, input logic [31:0] cm);
        if (a == 5'd0) return 32'd0;
        if (sm[a]) return 32'd0;
        if (cm[a]) return v ^ CORRUPT_XOR;
        return v;
    endfunction

    // Register file: writes on the rising edge, combinational faulty reads.
    always @(posedge clk) begin
        if (rw[0] && wreg[0] != 5'd0) rf0[wreg[0]] <= wdata[0];
        if (rw[1] && wreg[1] != 5'd0) rf1[wreg[1]] <= wdata[1];
    end

    always_comb begin
        rd1[0] = fault_val(rr1[0], rf0[rr1[0]], stuck0[0], corrupt[0]);
        rd2[0] = fault_val(rr2[0], rf0[rr2[0]], stuck0[0], corrupt[0]);
        rd1[1] = fault_val(rr1[1], rf1[rr1[1]], stuck0[1], corrupt[1]);
        rd2[1] = fault_val(rr2[1], rf1[rr2[1]], stuck0[1], corrupt[1]);
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    // Expected behaviour of one complete test on instance k, computed from the rules.
    function automatic void push_run(input int k, input int done_cyc);
        res_t  r;
        wr_t   w;
        rd_t   p;
        logic [31:0] ex, got;
        int    fc;
        r.inst = k; r.cyc = done_cyc; r.ff = 5'd0; fc = 0;
        for (int ps = 0; ps < PASSES; ps++) begin
            for (int i = fr(k); i <= lr(k); i++) begin
                w.inst = k; w.a = 5'(i); w.d = pat(k, i, ps);
                wr_q.push_back(w);
            end
            for (int i = fr(k); i <= lr(k); i += 2) begin
                p.inst = k; p.a1 = 5'(i); p.a2 = (i == lr(k)) ? 5'(i) : 5'(i + 1);
                rd_q.push_back(p);
                rd_q.push_back(p);
            end
            for (int i = fr(k); i <= lr(k); i++) begin
                ex  = (i == 0) ? 32'd0 : pat(k, i, ps);
                got = fault_val(5'(i), pat(k, i, ps), stuck0[k], corrupt[k]);
                if (got != ex) begin
                    if (fc == 0) r.ff = 5'(i);
                    fc = (fc < 63) ? fc + 1 : 63;
                end
            end
        end
        r.fc = 6'(fc);
        r.pass = (fc == 0);
        res_q.push_back(r);
        last_exp = r;
    endfunction

    always @(negedge clk) begin : mon
        wr_t  w;
        rd_t  p;
        res_t r;
        for (int k = 0; k < 2; k++) begin
            if (rw[k]) begin
                if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                else begin
                    w = wr_q.pop_front();
                    chk("wr_inst", k, w.inst);
                    chk("wr_addr", 32'(wreg[k]), 32'(w.a));
                    chk("wr_data", wdata[k], w.d);
                end
            end else if (busy[k]) begin
                if (rd_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
                else begin
                    p = rd_q.pop_front();
                    chk("rd_inst", k, p.inst);
                    chk("rd_addr1", 32'(rr1[k]), 32'(p.a1));
                    chk("rd_addr2", 32'(rr2[k]), 32'(p.a2));
                end
            end
            if (done[k]) begin
                if (res_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    r = res_q.pop_front();
                    chk("done_inst", k, r.inst);
                    chk("done_cycle", cyc, r.cyc);
                    chk("done_pass", 32'(pass[k]), 32'(r.pass));
                    chk("done_failcount", 32'(fcnt[k]), 32'(r.fc));
                    chk("done_firstfail", 32'(ffr[k]), 32'(r.ff));
                    chk("done_busy", 32'(busy[k]), 32'd0);
                end
            end
        end
    end

    task automatic drain(input int k);
        int b;
        b = 0;
        while ((res_q.size() + wr_q.size() + rd_q.size()) != 0 && b < 400) begin
            @(negedge clk);
            b++;
        end
        chk("drain", res_q.size() + wr_q.size() + rd_q.size(), 32'd0);
        res_q.delete(); wr_q.delete(); rd_q.delete();
        repeat (4) @(negedge clk);
        chk("hold_pass", 32'(pass[k]), 32'(last_exp.pass));
        chk("hold_failcount", 32'(fcnt[k]), 32'(last_exp.fc));
        chk("hold_firstfail", 32'(ffr[k]), 32'(last_exp.ff));
        chk("hold_busy", 32'(busy[k]), 32'd0);
    endtask

    // Start held for 'hold' cycles; a new test is accepted each time IDLE sees it.
    task automatic run(input int k, input int hold);
        int cs, n, lat, e;
        @(negedge clk);
        cs  = cyc;
        n   = lr(k) - fr(k) + 1;
        lat = PASSES * (n + 2 * ((n + 1) / 2));
        e   = 0;
        while (e < hold) begin
            push_run(k, cs + 1 + e + lat);
            e += lat + 2;
        end
        for (int c = 0; c < hold; c++) begin
            start[k] = 1'b1;
            @(negedge clk);
        end
        start[k] = 1'b0;
        drain(k);
    endtask

    task automatic reset_mid();
        wr_t w;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            w.inst = 0; w.a = 5'(8 + i); w.d = pat(0, 8 + i, 0);
            wr_q.push_back(w);
        end
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_regwrite", 32'(rw[0]), 32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_pass", 32'(pass[0]), 32'd0);
        chk("midrst_wreg", 32'(wreg[0]), 32'd0);
        repeat (3) @(negedge clk);
        chk("midrst_writes", wr_q.size(), 32'd0);
        wr_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 2'b00; stuck0 = '0; corrupt = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("rst_regwrite", 32'(rw[k]), 32'd0);
            chk("rst_wreg", 32'(wreg[k]), 32'd0);
            chk("rst_wdata", wdata[k], 32'd0);
            chk("rst_rreg1", 32'(rr1[k]), 32'd0);
            chk("rst_rreg2", 32'(rr2[k]), 32'd0);
            chk("rst_busy", 32'(busy[k]), 32'd0);
            chk("rst_done", 32'(done[k]), 32'd0);
            chk("rst_pass", 32'(pass[k]), 32'd0);
            chk("rst_failcount", 32'(fcnt[k]), 32'd0);
            chk("rst_firstfail", 32'(ffr[k]), 32'd0);
        end

        run(0, 1);
        stuck0[0][13] = 1'b1;
        run(0, 1);
        stuck0[0] = '0;
        corrupt[0][10] = 1'b1;
        corrupt[0][11] = 1'b1;
        run(0, 1);

        for (int r = 0; r < 4; r++) begin
            stuck0[0] = '0;
            corrupt[0] = '0;
            repeat ($urandom_range(1, 3)) begin
                if ($urandom_range(0, 1) == 1) stuck0[0][$urandom_range(25, 8)] = 1'b1;
                else corrupt[0][$urandom_range(25, 8)] = 1'b1;
            end
            run(0, 1);
        end
        stuck0[0] = '0;
        corrupt[0] = '0;

        run(0, 50);
        reset_mid();
        run(0, 1);
        run(1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
